// File: rtl/arb_pkg.sv
// Types and constants shared by the round-robin arbiter, its requester agents and the bench.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        GAP
    } arb_req_state_t;

    localparam int NUM_REQ = 3;

endpackage

// File: rtl/arb_job_fifo.sv
// Job-length queue for one requester: DEPTH x WIDTH synchronous FIFO, push and pop may coincide.
module arb_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit tells full from empty when the index bits match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign data_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for one arbiter port: queues burst jobs, requests, issues beats on grant.
//
// state | meaning
// IDLE  | no burst; pops next job when the queue has one
// REQ   | r high, waiting for first grant; counts wait cycles for timeout
// XFER  | r high, burst started; one beat per granted cycle
// GAP   | r low for one cycle so the arbiter can rotate
module arb_requester
    import arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_valid_i,
    input  logic [LEN_W-1:0] job_len_i,
    output logic             job_ready_o,
    output logic             r_o,
    input  logic             g_i,
    output logic             beat_valid_o,
    output logic             beat_last_o,
    output logic             busy_o,
    output logic             timeout_err_o,
    output logic             grant_err_o
);

    localparam int                WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    arb_req_state_t    state_q, state_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              r_q, r_d;
    logic              grant_err_q;

    logic              fifo_full, fifo_empty, pop;
    logic [LEN_W-1:0]  fifo_data;
    logic              in_burst;

    arb_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LEN_W)
    ) u_job_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (job_valid_i),
        .pop_i   (pop),
        .data_i  (job_len_i),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            r_q         <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            r_q         <= r_d;
            grant_err_q <= g_i & ~r_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pop           = 1'b0;
        timeout_err_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    beat_cnt_d = fifo_data;
                    wait_cnt_d = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (g_i) begin
                    wait_cnt_d = '0;
                    if (beat_cnt_q == '0) begin
                        state_d = GAP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                        state_d    = XFER;
                    end
                end else if (wait_cnt_q == WAIT_MAX) begin
                    // Keep requesting after a timeout; the pulse is only a warning.
                    timeout_err_o = 1'b1;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            XFER: begin
                if (g_i) begin
                    if (beat_cnt_q == '0) begin
                        state_d = GAP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
        endcase
        r_d = (state_d == REQ) || (state_d == XFER);
    end

    assign in_burst     = (state_q == REQ) || (state_q == XFER);
    assign beat_valid_o = g_i & r_q & in_burst;
    assign beat_last_o  = beat_valid_o & (beat_cnt_q == '0);
    assign r_o          = r_q;
    assign grant_err_o  = grant_err_q;
    assign busy_o       = (state_q != IDLE) | ~fifo_empty;
    assign job_ready_o  = ~fifo_full;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios plus random traffic against a queue-based model.
module tb_arb_requester;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             job_valid = 1'b0;
    logic [LEN_W-1:0] job_len = '0;
    logic             g = 1'b0;
    logic             job_ready, r, beat_valid, beat_last, busy, timeout_err, grant_err;

    always #5 clk = ~clk;

    arb_requester #(
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .job_valid_i   (job_valid),
        .job_len_i     (job_len),
        .job_ready_o   (job_ready),
        .r_o           (r),
        .g_i           (g),
        .beat_valid_o  (beat_valid),
        .beat_last_o   (beat_last),
        .busy_o        (busy),
        .timeout_err_o (timeout_err),
        .grant_err_o   (grant_err)
    );

    int total = 0;
    int bad   = 0;

    // obs/expv bit order: r, beat_valid, beat_last, busy, timeout_err, grant_err, job_ready
    logic [6:0] obs, expv;

    // Reference model: pending job lengths, beats left in the current burst, wait counter.
    int q[$];
    bit m_req, m_gap, m_granted, m_gerr;
    int m_rem, m_wait;

    function automatic void model_reset();
        q.delete();
        m_req = 0; m_gap = 0; m_granted = 0; m_gerr = 0;
        m_rem = 0; m_wait = 0;
    endfunction

    function automatic logic [6:0] model_out();
        logic bv, bl, to, bz, jr;
        bv = m_req && g;
        bl = bv && (m_rem == 1);
        to = m_req && !m_granted && !g && (m_wait == TIMEOUT - 1);
        bz = m_req || m_gap || (q.size() != 0);
        jr = (q.size() < DEPTH);
        return {m_req, bv, bl, bz, to, m_gerr, jr};
    endfunction

    function automatic void model_clock();
        bit push;
        int plen;
        if (rst) begin
            model_reset();
            return;
        end
        push   = job_valid && (q.size() < DEPTH);
        plen   = int'(job_len);
        m_gerr = g && !m_req;
        if (m_req) begin
            if (g) begin
                m_rem     = m_rem - 1;
                m_granted = 1;
                m_wait    = 0;
                if (m_rem == 0) begin
                    m_req = 0;
                    m_gap = 1;
                end
            end else if (!m_granted) begin
                m_wait = (m_wait == TIMEOUT - 1) ? 0 : m_wait + 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (q.size() != 0) begin
            m_rem     = q.pop_front() + 1;
            m_req     = 1;
            m_granted = 0;
            m_wait    = 0;
        end
        if (push) q.push_back(plen);
    endfunction

    task automatic step();
        @(negedge clk);
        obs  = {r, beat_valid, beat_last, busy, timeout_err, grant_err, job_ready};
        expv = model_out();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; job_valid = 1; job_len = 4'd5; g = 0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL reset_hold obs=%b exp=%b t=%0t", obs, expv, $time); end
        end
        total++;
        if (obs !== 7'b0000001) begin bad++; $display("FAIL reset_values obs=%b exp=%b", obs, 7'b0000001); end
        rst = 0; job_valid = 0;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL reset_release obs=%b exp=%b t=%0t", obs, expv, $time); end
        total++;
        if (obs[3] !== 1'b0) begin bad++; $display("FAIL reset_no_push busy=%b exp=0", obs[3]); end
    endtask

    task automatic test_single_burst();
        int rise, beats, last_beat;
        bit prev_r;
        rise = -1; beats = 0; last_beat = -1; prev_r = 0;
        g = 0; job_valid = 1; job_len = 4'd2;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL single_push obs=%b exp=%b t=%0t", obs, expv, $time); end
        job_valid = 0;
        for (int c = 1; c <= 10; c++) begin
            g = prev_r;
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL single_cycle obs=%b exp=%b t=%0t", obs, expv, $time); end
            prev_r = obs[6];
            if (obs[6] && rise < 0) rise = c;
            if (obs[5]) beats++;
            if (obs[4]) last_beat = beats;
        end
        g = 0;
        total++;
        if (rise !== 2) begin bad++; $display("FAIL single_rise got=%0d exp=2", rise); end
        total++;
        if (beats !== 3) begin bad++; $display("FAIL single_beats got=%0d exp=3", beats); end
        total++;
        if (last_beat !== 3) begin bad++; $display("FAIL single_last got=%0d exp=3", last_beat); end
    endtask

    task automatic test_preempt();
        logic [5:0] pat;
        int n, beats, off_grant;
        bit r_all;
        pat = 6'b101101; n = 0; beats = 0; off_grant = 0; r_all = 1;
        g = 0; job_valid = 1; job_len = 4'd3;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL preempt_push obs=%b exp=%b t=%0t", obs, expv, $time); end
        job_valid = 0;
        do begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL preempt_wait obs=%b exp=%b t=%0t", obs, expv, $time); end
            n++;
        end while (!obs[6] && n < 10);
        total++;
        if (obs[6] !== 1'b1) begin bad++; $display("FAIL preempt_req_timeout r=%b exp=1", obs[6]); end
        for (int i = 0; i < 6; i++) begin
            g = pat[5-i];
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL preempt_cycle obs=%b exp=%b t=%0t", obs, expv, $time); end
            if (obs[5]) beats++;
            if (obs[5] && !g) off_grant++;
            if (!obs[6]) r_all = 0;
        end
        g = 0;
        total++;
        if (beats !== 4) begin bad++; $display("FAIL preempt_beats got=%0d exp=4", beats); end
        total++;
        if (off_grant !== 0) begin bad++; $display("FAIL preempt_off_grant got=%0d exp=0", off_grant); end
        total++;
        if (r_all !== 1'b1) begin bad++; $display("FAIL preempt_r_held got=%b exp=1", r_all); end
        repeat (3) begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL preempt_tail obs=%b exp=%b t=%0t", obs, expv, $time); end
        end
    endtask

    task automatic test_timeout();
        int hits[$];
        int n;
        bit r_drop;
        n = 0; r_drop = 0;
        g = 0; job_valid = 1; job_len = 4'd0;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL timeout_push obs=%b exp=%b t=%0t", obs, expv, $time); end
        job_valid = 0;
        do begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL timeout_wait obs=%b exp=%b t=%0t", obs, expv, $time); end
            n++;
        end while (!obs[6] && n < 10);
        for (int c = 2; c <= 33; c++) begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL timeout_cycle obs=%b exp=%b t=%0t", obs, expv, $time); end
            if (obs[2]) hits.push_back(c);
            if (!obs[6]) r_drop = 1;
        end
        total++;
        if (hits.size() != 2) begin
            bad++; $display("FAIL timeout_count got=%0d exp=2", hits.size());
        end else if (hits[0] != 16 || hits[1] != 32) begin
            bad++; $display("FAIL timeout_cycles got=%0d,%0d exp=16,32", hits[0], hits[1]);
        end
        total++;
        if (r_drop) begin bad++; $display("FAIL timeout_r_held got=0 exp=1"); end
        g = 1;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL timeout_grant obs=%b exp=%b t=%0t", obs, expv, $time); end
        g = 0;
        repeat (3) begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL timeout_tail obs=%b exp=%b t=%0t", obs, expv, $time); end
        end
    endtask

    task automatic test_back_to_back();
        int lens[5];
        int got[$];
        int gaps[$];
        int cur, low_run;
        cur = 0; low_run = 0;
        g = 0;
        for (int i = 0; i < 5; i++) begin
            lens[i]   = int'($urandom_range(0, (1 << LEN_W) - 1));
            job_valid = 1;
            job_len   = LEN_W'(lens[i]);
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL b2b_push obs=%b exp=%b t=%0t", obs, expv, $time); end
        end
        job_len = 4'd9;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL b2b_sixth obs=%b exp=%b t=%0t", obs, expv, $time); end
        total++;
        if (obs[0] !== 1'b0) begin bad++; $display("FAIL b2b_stall job_ready=%b exp=0", obs[0]); end
        job_valid = 0;
        for (int c = 0; c < 400 && (m_req || m_gap || q.size() != 0); c++) begin
            g = m_req;
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL b2b_cycle obs=%b exp=%b t=%0t", obs, expv, $time); end
            if (obs[5]) cur++;
            if (obs[4]) begin got.push_back(cur); cur = 0; end
            if (obs[6]) begin
                if (low_run > 0) gaps.push_back(low_run);
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        g = 0;
        total++;
        if (got.size() != 5) begin
            bad++; $display("FAIL b2b_burst_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[i] != lens[i] + 1) begin bad++; $display("FAIL b2b_burst_len idx=%0d got=%0d exp=%0d", i, got[i], lens[i] + 1); end
            end
        end
        total++;
        if (gaps.size() != 4) begin
            bad++; $display("FAIL b2b_gap_count got=%0d exp=4", gaps.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (gaps[i] != 2) begin bad++; $display("FAIL b2b_gap_len idx=%0d got=%0d exp=2", i, gaps[i]); end
            end
        end
    endtask

    task automatic test_grant_err_and_reset();
        int beats, n, nb;
        beats = 0; n = 0; nb = 0;
        g = 1;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL gerr_idle obs=%b exp=%b t=%0t", obs, expv, $time); end
        total++;
        if (obs[5] !== 1'b0) begin bad++; $display("FAIL gerr_no_beat beat_valid=%b exp=0", obs[5]); end
        g = 0;
        step();
        total++;
        if (obs[1] !== 1'b1) begin bad++; $display("FAIL gerr_pulse grant_err=%b exp=1", obs[1]); end
        job_valid = 1; job_len = 4'd7;
        step();
        total++;
        if (obs !== expv) begin bad++; $display("FAIL rstmid_push obs=%b exp=%b t=%0t", obs, expv, $time); end
        job_valid = 0;
        while (beats < 2 && n < 20) begin
            g = m_req;
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL rstmid_run obs=%b exp=%b t=%0t", obs, expv, $time); end
            if (obs[5]) beats++;
            n++;
        end
        g = 1;
        #1;
        total++;
        if ({r, beat_valid} !== 2'b11) begin bad++; $display("FAIL rstmid_pre r_bv=%b exp=11", {r, beat_valid}); end
        #1;
        rst = 1;
        model_reset();
        #1;
        total++;
        if (r !== 1'b0) begin bad++; $display("FAIL rstmid_r r=%b exp=0", r); end
        total++;
        if (beat_valid !== 1'b0) begin bad++; $display("FAIL rstmid_bv beat_valid=%b exp=0", beat_valid); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy busy=%b exp=0", busy); end
        g = 0;
        step();
        rst = 0;
        repeat (6) begin
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL rstmid_after obs=%b exp=%b t=%0t", obs, expv, $time); end
            if (obs[5]) nb++;
        end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL rstmid_no_beats got=%0d exp=0", nb); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            job_valid = ($urandom_range(0, 2) == 0);
            job_len   = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
            g         = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 199) == 0);
            if (rst) model_reset();
            step();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL random obs=%b exp=%b t=%0t", obs, expv, $time); end
        end
        rst = 0; job_valid = 0; g = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_burst();
        test_preempt();
        test_timeout();
        test_back_to_back();
        test_grant_err_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
